// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and encodings for the pipeline hazard controller
//
// Contents:
//   state_e      controller FSM state (RUN, MEM_WAIT)
//   FWD_*        EX-stage operand source select encodings
//   WAIT_CNT_W   width of the memory-wait cycle counter
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
//
// Pipeline-side information (driven by master): ID/EX/MEM/WB register
// numbers and write/read flags, branch resolution, data memory handshake.
// Controller outputs (driven by slave): PC and pipeline register enables,
// flushes, MEM/WB bubble, forwarding selects, timeout flag, perf counters.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic [4:0]       ex_wn;
    logic             ex_RegWrite;
    logic             ex_MemRead;
    logic [4:0]       mem_wn;
    logic             mem_RegWrite;
    logic [4:0]       wb_wn;
    logic             wb_RegWrite;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_wn, ex_RegWrite,
               ex_MemRead, mem_wn, mem_RegWrite, wb_wn, wb_RegWrite,
               branch_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble,
               fwd_a, fwd_b, timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_wn, ex_RegWrite,
               ex_MemRead, mem_wn, mem_RegWrite, wb_wn, wb_RegWrite,
               branch_taken, mem_req, mem_ready,
        output pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble,
               fwd_a, fwd_b, timeout_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// rtl/pipe_hazard_ctrl_fwd.sv - combinational forwarding select for one EX operand
//
// Ports:
//   src_i            EX operand source register
//   mem_wn_i         MEM stage destination register
//   mem_reg_write_i  MEM stage writes the register file
//   wb_wn_i          WB stage destination register
//   wb_reg_write_i   WB stage writes the register file
//   sel_o            operand select (FWD_MEM over FWD_WB over FWD_RF)
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic [4:0] mem_wn_i,
    input  logic       mem_reg_write_i,
    input  logic [4:0] wb_wn_i,
    input  logic       wb_reg_write_i,
    output logic [1:0] sel_o
);

    // MEM holds the younger result, so it must win over WB; r0 is never forwarded.
    always_comb begin
        sel_o = FWD_RF;
        if (mem_reg_write_i && (mem_wn_i != 5'd0) && (mem_wn_i == src_i)) begin
            sel_o = FWD_MEM;
        end else if (wb_reg_write_i && (wb_wn_i != 5'd0) && (wb_wn_i == src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forwarding controller for the 5-stage pipeline
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   slave side of pipe_hazard_ctrl_if (hazard inputs, enables/flushes,
//         forwarding selects, timeout flag, saturating stall/flush counters)
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_V = WAIT_CNT_W'(WAIT_TIMEOUT);

    state_e                  state_q, state_d;
    logic                    pending_q, pending_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    timeout_q, timeout_d;
    logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]        flush_cnt_q, flush_cnt_d;

    logic frozen;
    logic flush;
    logic load_use;
    logic stall;

    logic       pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble;
    logic [1:0] fwd_a, fwd_b;

    fwd_unit u_fwd_a (
        .src_i           (bus.ex_rs),
        .mem_wn_i        (bus.mem_wn),
        .mem_reg_write_i (bus.mem_RegWrite),
        .wb_wn_i         (bus.wb_wn),
        .wb_reg_write_i  (bus.wb_RegWrite),
        .sel_o           (fwd_a)
    );

    fwd_unit u_fwd_b (
        .src_i           (bus.ex_rt),
        .mem_wn_i        (bus.mem_wn),
        .mem_reg_write_i (bus.mem_RegWrite),
        .wb_wn_i         (bus.wb_wn),
        .wb_reg_write_i  (bus.wb_RegWrite),
        .sel_o           (fwd_b)
    );

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;

        // The freeze starts in the very cycle the access misses, not one later.
        frozen = 1'b0;
        case (state_q)
            RUN: begin
                frozen = bus.mem_req && !bus.mem_ready;
                if (frozen) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                frozen = !bus.mem_ready;
                if (!frozen) state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        // A branch seen while frozen is remembered and applied on release.
        flush    = !frozen && (bus.branch_taken || pending_q);
        load_use = bus.ex_MemRead && bus.ex_RegWrite && (bus.ex_wn != 5'd0) &&
                   ((bus.ex_wn == bus.id_rs) ||
                    (bus.id_uses_rt && (bus.ex_wn == bus.id_rt)));
        stall    = !frozen && !flush && load_use;

        if (frozen) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            pending_d    = pending_q || bus.branch_taken;
        end else if (flush) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            pending_d    = 1'b0;
        end else if (stall) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_flush   = 1'b1;
        end

        // Count every frozen cycle, including the one that enters MEM_WAIT.
        if (frozen) begin
            if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = '0;
        end
        if (wait_cnt_d >= TIMEOUT_V) timeout_d = 1'b1;

        if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && (flush_cnt_q != '1))  flush_cnt_d = flush_cnt_q + 1'b1;

        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pending_q   <= 1'b0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.ifid_en      = ifid_en;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_flush   = idex_flush;
    assign bus.exmem_en     = exmem_en;
    assign bus.memwb_bubble = memwb_bubble;
    assign bus.fwd_a        = rst ? FWD_RF : fwd_a;
    assign bus.fwd_b        = rst ? FWD_RF : fwd_b;
    assign bus.timeout_err  = timeout_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int WT   = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    // Expected output vector: {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble, fwd_a, fwd_b}
    localparam logic [9:0] E_IDLE  = 10'b1100100000;
    localparam logic [9:0] E_STALL = 10'b0001100000;
    localparam logic [9:0] E_FLUSH = 10'b1111100000;
    localparam logic [9:0] E_FROZ  = 10'b0000010000;
    localparam logic [9:0] E_RESET = 10'b0011010000;
    localparam logic [9:0] FA_MEM  = 10'h008;
    localparam logic [9:0] FA_WB   = 10'h004;
    localparam logic [9:0] FB_WB   = 10'h001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.WAIT_TIMEOUT(WT), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state (counts as plain integers)
    bit m_valid = 0;
    bit m_wait  = 0;
    bit m_owed  = 0;
    bit m_to    = 0;
    int m_waited = 0;
    int m_stalls = 0;
    int m_flushes = 0;

    function automatic logic [1:0] fwd_model(input int src);
        if (bus.mem_RegWrite && bus.mem_wn != 0 && int'(bus.mem_wn) == src) return 2'b10;
        if (bus.wb_RegWrite && bus.wb_wn != 0 && int'(bus.wb_wn) == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0;
        bus.ex_rs = 0; bus.ex_rt = 0; bus.ex_wn = 0;
        bus.ex_RegWrite = 0; bus.ex_MemRead = 0;
        bus.mem_wn = 0; bus.mem_RegWrite = 0;
        bus.wb_wn = 0; bus.wb_RegWrite = 0;
        bus.branch_taken = 0; bus.mem_req = 0; bus.mem_ready = 1;
    endtask

    // Entered at posedge+1; checks at the falling edge, returns at the next posedge+1.
    task automatic tick(input string tag, input bit use_tab, input logic [9:0] tab);
        bit frz, fl, lu, st;
        logic [9:0] e, act;
        bit n_wait, n_owed, n_to;
        int n_waited, n_stalls, n_flushes;
        #4;
        act = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush, bus.exmem_en,
               bus.memwb_bubble, bus.fwd_a, bus.fwd_b};
        frz = 0; fl = 0; st = 0;
        if (rst) begin
            e = E_RESET;
        end else begin
            frz = !bus.mem_ready && (m_wait || bus.mem_req);
            fl  = !frz && (bus.branch_taken || m_owed);
            lu  = bus.ex_MemRead && bus.ex_RegWrite && bus.ex_wn != 0 &&
                  (bus.ex_wn == bus.id_rs || (bus.id_uses_rt && bus.ex_wn == bus.id_rt));
            st  = !frz && !fl && lu;
            e = {!(frz || st), !(frz || st), fl, fl || st, !frz, frz,
                 fwd_model(int'(bus.ex_rs)), fwd_model(int'(bus.ex_rt))};
        end
        if (use_tab) chk({tag, " outputs"}, 32'(act), 32'(tab));
        chk({tag, " model outputs"}, 32'(act), 32'(e));
        if (m_valid) begin
            chk({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'(m_stalls));
            chk({tag, " flush_cnt"}, 32'(bus.flush_cnt), 32'(m_flushes));
            chk({tag, " timeout_err"}, 32'(bus.timeout_err), 32'(m_to));
        end
        if (rst) begin
            n_wait = 0; n_owed = 0; n_to = 0; n_waited = 0; n_stalls = 0; n_flushes = 0;
        end else begin
            n_wait    = frz;
            n_owed    = frz && (m_owed || bus.branch_taken);
            n_waited  = frz ? ((m_waited < 255) ? m_waited + 1 : 255) : 0;
            n_to      = m_to || (n_waited >= WT);
            n_stalls  = (frz || st) ? ((m_stalls < CMAX) ? m_stalls + 1 : CMAX) : m_stalls;
            n_flushes = fl ? ((m_flushes < CMAX) ? m_flushes + 1 : CMAX) : m_flushes;
        end
        @(posedge clk);
        #1;
        if (rst) m_valid = 1;
        m_wait = n_wait; m_owed = n_owed; m_to = n_to;
        m_waited = n_waited; m_stalls = n_stalls; m_flushes = n_flushes;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick("reset", 1, E_RESET);
        rst = 0;
    endtask

    typedef struct packed {
        logic [4:0] id_rs, id_rt;
        logic       uses_rt;
        logic [4:0] ex_rs, ex_rt, ex_wn;
        logic       ex_rw, ex_mr;
        logic [4:0] mem_wn;
        logic       mem_rw;
        logic [4:0] wb_wn;
        logic       wb_rw;
        logic       br, mreq, mrdy;
        logic [9:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic apply_vec(input vec_t v);
        bus.id_rs = v.id_rs; bus.id_rt = v.id_rt; bus.id_uses_rt = v.uses_rt;
        bus.ex_rs = v.ex_rs; bus.ex_rt = v.ex_rt; bus.ex_wn = v.ex_wn;
        bus.ex_RegWrite = v.ex_rw; bus.ex_MemRead = v.ex_mr;
        bus.mem_wn = v.mem_wn; bus.mem_RegWrite = v.mem_rw;
        bus.wb_wn = v.wb_wn; bus.wb_RegWrite = v.wb_rw;
        bus.branch_taken = v.br; bus.mem_req = v.mreq; bus.mem_ready = v.mrdy;
    endtask

    initial begin
        vec_t v;

        // Single-cycle vectors, each applied from RUN with a reset afterwards
        v = '0; v.mrdy = 1; v.exp = E_IDLE; vq.push_back(v);
        v = '0; v.mrdy = 1; v.ex_mr = 1; v.ex_rw = 1; v.ex_wn = 8; v.id_rs = 8; v.exp = E_STALL; vq.push_back(v);
        v = '0; v.mrdy = 1; v.ex_mr = 1; v.ex_rw = 1; v.ex_wn = 0; v.id_rs = 0; v.exp = E_IDLE; vq.push_back(v);
        v = '0; v.mrdy = 1; v.ex_mr = 1; v.ex_rw = 1; v.ex_wn = 9; v.id_rt = 9; v.uses_rt = 1; v.exp = E_STALL; vq.push_back(v);
        v = '0; v.mrdy = 1; v.ex_mr = 1; v.ex_rw = 1; v.ex_wn = 9; v.id_rt = 9; v.uses_rt = 0; v.exp = E_IDLE; vq.push_back(v);
        v = '0; v.mrdy = 1; v.ex_mr = 1; v.ex_rw = 0; v.ex_wn = 8; v.id_rs = 8; v.exp = E_IDLE; vq.push_back(v);
        v = '0; v.mrdy = 1; v.ex_mr = 0; v.ex_rw = 1; v.ex_wn = 8; v.id_rs = 8; v.exp = E_IDLE; vq.push_back(v);
        v = '0; v.mrdy = 1; v.br = 1; v.exp = E_FLUSH; vq.push_back(v);
        v = '0; v.mrdy = 1; v.br = 1; v.ex_mr = 1; v.ex_rw = 1; v.ex_wn = 8; v.id_rs = 8; v.exp = E_FLUSH; vq.push_back(v);
        v = '0; v.mrdy = 1; v.mem_wn = 5; v.mem_rw = 1; v.wb_wn = 5; v.wb_rw = 1; v.ex_rs = 5; v.exp = E_IDLE | FA_MEM; vq.push_back(v);
        v = '0; v.mrdy = 1; v.mem_wn = 5; v.mem_rw = 0; v.wb_wn = 5; v.wb_rw = 1; v.ex_rs = 5; v.exp = E_IDLE | FA_WB; vq.push_back(v);
        v = '0; v.mrdy = 1; v.wb_wn = 5; v.wb_rw = 1; v.ex_rt = 5; v.ex_rs = 6; v.exp = E_IDLE | FB_WB; vq.push_back(v);
        v = '0; v.mrdy = 1; v.mem_wn = 0; v.mem_rw = 1; v.wb_wn = 0; v.wb_rw = 1; v.exp = E_IDLE; vq.push_back(v);
        v = '0; v.mrdy = 1; v.mem_wn = 3; v.mem_rw = 1; v.ex_rs = 3; v.wb_wn = 7; v.wb_rw = 1; v.ex_rt = 7; v.exp = E_IDLE | FA_MEM | FB_WB; vq.push_back(v);
        v = '0; v.mreq = 1; v.mrdy = 0; v.br = 1; v.mem_wn = 4; v.mem_rw = 1; v.ex_rs = 4; v.exp = E_FROZ | FA_MEM; vq.push_back(v);
        v = '0; v.mreq = 1; v.mrdy = 1; v.exp = E_IDLE; vq.push_back(v);

        clear_inputs();
        rst = 1;
        @(posedge clk);
        #1;

        // Reset held for two cycles
        tick("rst0", 1, E_RESET);
        tick("rst1", 1, E_RESET);
        chk("reset stall_cnt", 32'(bus.stall_cnt), 0);
        chk("reset flush_cnt", 32'(bus.flush_cnt), 0);
        chk("reset timeout_err", 32'(bus.timeout_err), 0);
        rst = 0;
        tick("post_reset", 1, E_IDLE);

        for (int i = 0; i < vq.size(); i++) begin
            apply_vec(vq[i]);
            tick($sformatf("vec%0d", i), 1, vq[i].exp);
            do_reset();
        end

        // Load-use stall lasts exactly one cycle and is counted
        do_reset();
        bus.ex_MemRead = 1; bus.ex_RegWrite = 1; bus.ex_wn = 8; bus.id_rs = 8;
        tick("loaduse", 1, E_STALL);
        chk("loaduse stall_cnt", 32'(bus.stall_cnt), 1);
        clear_inputs();
        tick("loaduse_after", 1, E_IDLE);
        bus.ex_MemRead = 1; bus.ex_RegWrite = 1; bus.ex_wn = 0; bus.id_rs = 0;
        tick("loaduse_r0", 1, E_IDLE);
        chk("loaduse_r0 stall_cnt", 32'(bus.stall_cnt), 1);

        // Three-cycle memory wait then release
        do_reset();
        bus.mem_req = 1; bus.mem_ready = 0;
        for (int i = 0; i < 3; i++) tick("memwait", 1, E_FROZ);
        chk("memwait stall_cnt", 32'(bus.stall_cnt), 3);
        bus.mem_ready = 1;
        tick("memwait_release", 1, E_IDLE);
        chk("release stall_cnt", 32'(bus.stall_cnt), 3);
        chk("release flush_cnt", 32'(bus.flush_cnt), 0);
        bus.mem_req = 0;
        tick("memwait_idle", 1, E_IDLE);

        // Branch during freeze is deferred to the release cycle
        do_reset();
        bus.mem_req = 1; bus.mem_ready = 0;
        tick("bfz_w1", 1, E_FROZ);
        bus.branch_taken = 1;
        tick("bfz_w2", 1, E_FROZ);
        bus.branch_taken = 0;
        tick("bfz_w3", 1, E_FROZ);
        chk("bfz frozen flush_cnt", 32'(bus.flush_cnt), 0);
        bus.mem_ready = 1;
        tick("bfz_release", 1, E_FLUSH);
        chk("bfz flush_cnt", 32'(bus.flush_cnt), 1);
        bus.mem_req = 0;
        tick("bfz_after", 1, E_IDLE);
        chk("bfz after flush_cnt", 32'(bus.flush_cnt), 1);

        // Timeout after WT wait cycles, sticky until reset
        do_reset();
        bus.mem_req = 1; bus.mem_ready = 0;
        for (int i = 0; i < WT - 1; i++) tick("to_wait", 1, E_FROZ);
        chk("timeout early", 32'(bus.timeout_err), 0);
        tick("to_wait_last", 1, E_FROZ);
        chk("timeout set", 32'(bus.timeout_err), 1);
        bus.mem_ready = 1;
        tick("to_release", 1, E_IDLE);
        chk("timeout sticky release", 32'(bus.timeout_err), 1);
        bus.mem_req = 0;
        tick("to_idle", 1, E_IDLE);
        chk("timeout sticky idle", 32'(bus.timeout_err), 1);
        rst = 1;
        tick("to_rst", 1, E_RESET);
        chk("timeout cleared", 32'(bus.timeout_err), 0);
        rst = 0;

        // Randomized run against the reference model
        for (int n = 0; n < 3000; n++) begin
            bus.id_rs = 5'($urandom_range(0, 3));
            bus.id_rt = 5'($urandom_range(0, 3));
            bus.id_uses_rt = 1'($urandom_range(0, 1));
            bus.ex_rs = 5'($urandom_range(0, 3));
            bus.ex_rt = 5'($urandom_range(0, 3));
            bus.ex_wn = 5'($urandom_range(0, 3));
            bus.ex_RegWrite = 1'($urandom_range(0, 1));
            bus.ex_MemRead = 1'($urandom_range(0, 1));
            bus.mem_wn = 5'($urandom_range(0, 3));
            bus.mem_RegWrite = 1'($urandom_range(0, 1));
            bus.wb_wn = 5'($urandom_range(0, 3));
            bus.wb_RegWrite = 1'($urandom_range(0, 1));
            bus.branch_taken = ($urandom_range(0, 5) == 0);
            bus.mem_req = 1'($urandom_range(0, 1));
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick("random", 0, '0);
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush/forwarding controller for the 5-stage pipeline. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers through four mechanisms:
- per-register enables and flushes;
- load-use stalls;
- branch flushes;
- freezing the whole pipe while data memory is not ready.
It also drives the EX-stage forwarding selects and keeps saturating stall/flush performance counters.

Parameters:
WAIT_TIMEOUT, 255, max consecutive MEM_WAIT cycles before timeout_err sets (1..255)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
id_rs  in  5  rs of instruction in ID
id_rt  in  5  rt of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_rs  in  5  rs of instruction in EX
ex_rt  in  5  rt of instruction in EX
ex_wn  in  5  EX destination register
ex_RegWrite  in  1  EX writes register file
ex_MemRead  in  1  EX instruction is a load
mem_wn  in  5  MEM destination register
mem_RegWrite  in  1  MEM writes register file
wb_wn  in  5  WB destination register
wb_RegWrite  in  1  WB writes register file
branch_taken  in  1  branch/jump resolved taken in EX
mem_req  in  1  MEM stage issues a data memory access
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID load NOP
idex_flush  out  1  ID/EX load bubble (control bits 0)
exmem_en  out  1  EX/MEM load enable (also gates ID/EX)
memwb_bubble  out  1  MEM/WB loads RegWrite=0
fwd_a  out  2  EX operand A select: 00 regfile, 10 MEM, 01 WB
fwd_b  out  2  EX operand B select, same encoding
timeout_err  out  1  sticky memory-wait timeout flag
stall_cnt  out  CNT_W  saturating count of stalled cycles
flush_cnt  out  CNT_W  saturating count of branch flushes

Behaviour:
- FSM states: RUN, MEM_WAIT. State, pending_flush, wait_cnt (8b), timeout_err and counters are all registered.
- Reset (rst=1 at posedge): state=RUN; pending_flush=0; wait_cnt=0; timeout_err=0; stall_cnt=0; flush_cnt=0.
- Outputs while rst=1: pc_en=0, ifid_en=0, exmem_en=0, ifid_flush=1, idex_flush=1, memwb_bubble=1, fwd_a=fwd_b=00.
- Defaults when not in reset: pc_en=ifid_en=exmem_en=1; flushes=0; memwb_bubble=0.
- Hazard outputs are combinational from current state and inputs. Priority: MEM_WAIT freeze > branch flush > load-use stall.
- RUN -> MEM_WAIT when mem_req=1 and mem_ready=0. In that cycle and every MEM_WAIT cycle with mem_ready=0:
  - pc_en=ifid_en=exmem_en=0;
  - memwb_bubble=1;
  - no flush asserted.
- MEM_WAIT -> RUN on mem_ready=1. In that release cycle: all enables=1, memwb_bubble=0, and any pending flush is applied.
- branch_taken=1 while frozen: pending_flush<=1 and branch_taken is ignored thereafter until release. On release, ifid_flush=idex_flush=1, pending_flush<=0, and flush_cnt increments once.
- Branch in RUN (not frozen): ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt+1.
- Load-use: ex_MemRead & ex_RegWrite & ex_wn!=0 & (ex_wn==id_rs | (id_uses_rt & ex_wn==id_rt)). When this holds and there is no freeze and no branch: pc_en=0, ifid_en=0, idex_flush=1 for exactly that cycle. The condition clears by itself once the load advances.
- Branch and load-use in the same cycle: branch wins, no stall.
- Forwarding per operand (rs -> fwd_a, rt -> fwd_b):
  - 10 if mem_RegWrite & mem_wn!=0 & mem_wn==ex_x;
  - else 01 if wb_RegWrite & wb_wn!=0 & wb_wn==ex_x;
  - else 00.
  - MEM has priority over WB. Forwarding is unaffected by freeze.
- wait_cnt:
  - clears on entering RUN; increments each MEM_WAIT cycle.
  - When it reaches WAIT_TIMEOUT, timeout_err<=1 (sticky until rst). The FSM keeps waiting; no forced release.
- stall_cnt: +1 in every cycle with pc_en=0 (freeze or load-use); saturates at all-ones.
- flush_cnt: saturates at all-ones.
- Reset mid-MEM_WAIT returns to RUN and discards pending_flush.

Decomposition:
- Shared package pipe_ctrl_pkg: FSM state enum (RUN, MEM_WAIT); forwarding encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module fwd_unit (pure combinational, instantiated for operand A and B); FSM and counters stay in the top.

Test Plan:
- Reset: rst=1 for 2 cycles -> pc_en=0, ifid_flush=1, counters=0; rst=0 -> pc_en=ifid_en=exmem_en=1, fwd=00.
- Load-use: ex_MemRead=1, ex_RegWrite=1, ex_wn=8, id_rs=8 -> one cycle pc_en=0, ifid_en=0, idex_flush=1, stall_cnt=1. Repeat with ex_wn=0 -> no stall.
- Forwarding: mem_wn=5, wb_wn=5, both RegWrite=1, ex_rs=5 -> fwd_a=10. mem_RegWrite=0 -> fwd_a=01. ex_rt=5 with wb only -> fwd_b=01.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then ready -> 3 cycles all enables=0 and memwb_bubble=1; release cycle enables=1; stall_cnt=3.
- Branch during freeze: branch_taken=1 at wait cycle 2 -> no flush while frozen; on the mem_ready cycle ifid_flush=idex_flush=1, flush_cnt=1.
- Timeout: WAIT_TIMEOUT=4, mem_ready held 0 -> timeout_err=1 after 4 wait cycles and stays 1 after release; cleared only by rst.
